// File: rtl/mul_seq_signed.sv
// ---------------------------------------------------------------------------
// mul_seq_signed
// Sequential shift-add multiplier for 64-bit sign/magnitude operands.
// Its output feeds the 128->64 modular reducer: product is a 2*DW-bit
// two's-complement value, and done is a one-cycle pulse that can drive
// the reducer's enable input directly.
//
// Build option:
//   MUL_RADIX4_EN defined   -> radix-4: two multiplier bits per cycle,
//                              N = DW/2 iterations (DW must be even)
//   MUL_RADIX4_EN undefined -> radix-2: one multiplier bit per cycle,
//                              N = DW iterations
// Ports, output encoding and handshake are the same in both builds.
// Only the latency differs: start->done is N+1 cycles.
// ---------------------------------------------------------------------------
module mul_seq_signed #(
   parameter int DW    = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DW-1:0]   a,
   input  logic            a_sign,
   input  logic [DW-1:0]   b,
   input  logic            b_sign,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] product,
   output logic            product_sign
);

`ifdef MUL_RADIX4_EN
   localparam int K = 2;
`else
   localparam int K = 1;
`endif

   localparam int PW = 2 * DW;
   localparam int N  = DW / K;

   // The counter reaches LAST_CNT after the final accumulation.
   // The cycle spent at LAST_CNT formats the result.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [DW-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic            neg_q, neg_d;
   logic [PW-1:0]   product_q, product_d;
   logic            product_sign_q, product_sign_d;
   logic [PW-1:0]   pp;

`ifdef MUL_RADIX4_EN
   logic [PW-1:0]   mcand3_q, mcand3_d;
   logic [PW-1:0]   a_ext;
   logic [PW-1:0]   a_times3;

   // Compute the 3x multiple once at accept so each iteration needs only one adder.
   always_comb begin
      a_ext    = {{DW{1'b0}}, a};
      a_times3 = (a_ext << 1) + a_ext;
   end

   // Select the radix-4 partial product from the two multiplier LSBs.
   always_comb begin
      pp = '0;
      case (mplier_q[1:0])
         2'd0:    pp = '0;
         2'd1:    pp = mcand_q;
         2'd2:    pp = mcand_q << 1;
         default: pp = mcand3_q;
      endcase
   end
`else
   // Select the radix-2 partial product: the multiplicand or nothing.
   always_comb begin
      pp = '0;
      if (mplier_q[0]) begin
         pp = mcand_q;
      end
   end
`endif

   // Next-state logic: accept, iterate, format, then pulse done.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mcand_d        = mcand_q;
      mplier_d       = mplier_q;
      acc_d          = acc_q;
      neg_d          = neg_q;
      product_d      = product_q;
      product_sign_d = product_sign_q;
`ifdef MUL_RADIX4_EN
      mcand3_d       = mcand3_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_RUN;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = {{DW{1'b0}}, a};
               mplier_d = b;
               neg_d    = a_sign ^ b_sign;
`ifdef MUL_RADIX4_EN
               mcand3_d = a_times3;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            if (cnt_q != LAST_CNT) begin
               acc_d    = acc_q + pp;
               mplier_d = mplier_q >> K;
               mcand_d  = mcand_q << K;
`ifdef MUL_RADIX4_EN
               mcand3_d = mcand3_q << K;
`endif
               cnt_d    = cnt_q + CNT_W'(1);
            end else begin
               // A zero magnitude is never reported as negative.
               product_d      = neg_q ? (~acc_q + PW'(1)) : acc_q;
               product_sign_d = neg_q & (|acc_q);
               state_d        = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         mcand_q        <= '0;
         mplier_q       <= '0;
         acc_q          <= '0;
         neg_q          <= 1'b0;
         product_q      <= '0;
         product_sign_q <= 1'b0;
`ifdef MUL_RADIX4_EN
         mcand3_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mcand_q        <= mcand_d;
         mplier_q       <= mplier_d;
         acc_q          <= acc_d;
         neg_q          <= neg_d;
         product_q      <= product_d;
         product_sign_q <= product_sign_d;
`ifdef MUL_RADIX4_EN
         mcand3_q       <= mcand3_d;
`endif
      end
   end

   // Handshake outputs are decoded straight from the state register.
   always_comb begin
      busy         = (state_q == S_RUN);
      done         = (state_q == S_DONE);
      product      = product_q;
      product_sign = product_sign_q;
   end

endmodule

// File: tb/tb_mul_seq_signed.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_signed
// Scoreboard bench for mul_seq_signed. Each accepted operation pushes the
// model result and its expected done cycle. A monitor pops and compares
// on every done pulse.
// ---------------------------------------------------------------------------
module tb_mul_seq_signed;

`ifdef MUL_RADIX4_EN
   localparam int N = 32;
`else
   localparam int N = 64;
`endif

   typedef struct {
      logic [127:0] prod;
      logic         sgn;
      longint       cyc;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [63:0]   a;
   logic          a_sign;
   logic [63:0]   b;
   logic          b_sign;
   logic          busy;
   logic          done;
   logic [127:0]  product;
   logic          product_sign;

   exp_t          sb[$];
   logic [127:0]  last_prod;
   longint        cycle;
   int            n_checks;
   int            n_fail;

   mul_seq_signed #(.DW(64), .CNT_W(7)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .a_sign       (a_sign),
      .b            (b),
      .b_sign       (b_sign),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .product_sign (product_sign)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so the bench can check done latency.
   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Reference model: plain 128-bit multiply of magnitudes, then apply the sign.
   function automatic exp_t modelProduct(input logic [63:0] ma, input logic sa,
                                         input logic [63:0] mb, input logic sb_in);
      exp_t         e;
      logic [127:0] mag;
      logic         neg;
      mag    = {64'd0, ma} * {64'd0, mb};
      neg    = (sa != sb_in) && (mag != 128'd0);
      e.prod = neg ? (128'd0 - mag) : mag;
      e.sgn  = neg;
      e.cyc  = 0;
      return e;
   endfunction

   // Compare one value against its expected value and record the outcome.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive start now (caller is at a negedge) and log the expected result.
   // Assumes the request will be accepted.
   task automatic issueNow(input logic [63:0] ia, input logic ias, input logic [63:0] ib, input logic ibs);
      exp_t e;
      a      = ia;
      a_sign = ias;
      b      = ib;
      b_sign = ibs;
      start  = 1'b1;
      @(posedge clk);
      #1;
      e     = modelProduct(ia, ias, ib, ibs);
      e.cyc = cycle + N + 1;
      sb.push_back(e);
      start = 1'b0;
   endtask

   // Wait (bounded) until the multiplier can accept a request, then issue it.
   task automatic applyStimulus(input logic [63:0] ia, input logic ias, input logic [63:0] ib, input logic ibs);
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL busy_timeout: got busy=%b, expected 0", busy);
      end
      issueNow(ia, ias, ib, ibs);
   endtask

   // Monitor: pop the scoreboard on every done pulse.
   // While busy, also check that the last result is held.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL spurious_done: got done=1, expected no pending result");
            end else begin
               e = sb.pop_front();
               checkOutput("product", product, e.prod);
               checkOutput("product_sign", {127'd0, product_sign}, {127'd0, e.sgn});
               checkOutput("busy_in_done", {127'd0, busy}, 128'd0);
               checkOutput("done_cycle", 128'(cycle), 128'(e.cyc));
               last_prod = e.prod;
            end
         end else if (busy) begin
            checkOutput("product_hold", product, last_prod);
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      int guard;
      n_checks  = 0;
      n_fail    = 0;
      last_prod = 128'd0;
      rst       = 1'b1;
      start     = 1'b1;
      a         = 64'd9;
      a_sign    = 1'b0;
      b         = 64'd9;
      b_sign    = 1'b0;

      // Reset must override start.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", {127'd0, busy}, 128'd0);
      checkOutput("reset_done", {127'd0, done}, 128'd0);
      checkOutput("reset_product", product, 128'd0);
      checkOutput("reset_sign", {127'd0, product_sign}, 128'd0);
      start = 1'b0;
      rst   = 1'b0;

      // Directed cases: positive, negative, both negative, negative zero, all-ones.
      applyStimulus(64'd3, 1'b0, 64'd5, 1'b0);
      applyStimulus(64'd3, 1'b1, 64'd5, 1'b0);
      applyStimulus(64'd3, 1'b1, 64'd5, 1'b1);
      applyStimulus(64'd0, 1'b1, 64'd7, 1'b0);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd1, 1'b0);

      // A start pulse mid-RUN is ignored.
      applyStimulus(64'd123456789, 1'b0, 64'd987654321, 1'b1);
      repeat (10) @(negedge clk);
      a      = 64'd77;
      b      = 64'd88;
      a_sign = 1'b1;
      b_sign = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;

      // Back-to-back: start held in the DONE cycle.
      guard = 0;
      @(negedge clk);
      while (!done && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL done_timeout: got done=0, expected 1");
      end
      issueNow(64'hDEAD_BEEF_0123_4567, 1'b1, 64'hCAFE_F00D_89AB_CDEF, 1'b0);

      // Reset at iteration 20 aborts the operation without a done pulse.
      applyStimulus(64'd1111, 1'b0, 64'd2222, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy", {127'd0, busy}, 128'd0);
      checkOutput("abort_done", {127'd0, done}, 128'd0);
      checkOutput("abort_product", product, 128'd0);
      sb.delete();
      last_prod = 128'd0;
      rst = 1'b0;
      applyStimulus(64'd6, 1'b1, 64'd7, 1'b0);

      // Random operands, with occasional zero and all-ones magnitudes.
      for (int i = 0; i < 24; i++) begin
         logic [63:0] ra;
         logic [63:0] rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) ra = 64'd0;
         if ($urandom_range(0, 7) == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
         applyStimulus(ra, 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)));
      end

      // Let every pending result drain before checking the scoreboard is empty.
      guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("scoreboard_drained", 128'(sb.size()), 128'd0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
